// File: rtl/uart_tx_bus_peripheral.sv
// uart_tx_bus_peripheral
//
// Purpose: memory-mapped 8N1 UART transmitter on the shared 8-bit processor
// bus. Bytes written to BaseAddr+0 are queued in a small TX FIFO and
// serialised on TXD. The block raises a bus interrupt when the transmitter
// drains, if that interrupt is enabled.
//
// Register map (offsets from BaseAddr):
//   +0  W: push byte into FIFO     R: {zero, count}
//   +1  W: CTRL {.., clr_ovf, flush, irq_en}
//       R: STATUS {3'b0, overflow, irq_pending, busy, full, empty}
//   +2  R/W: bit0 = irq_enable
//
// Ports:
//   CLK                  system clock, all logic on its rising edge
//   RESET                asynchronous active-low reset
//   BUS_DATA             shared bidirectional data bus (Z unless reading us)
//   BUS_ADDR             bus address
//   BUS_WE               1 = processor write, 0 = read
//   BUS_INTERRUPT_RAISE  TX-drained interrupt request
//   BUS_INTERRUPT_ACK    interrupt acknowledge from processor
//   TXD                  serial output, idle high
module uart_tx_bus_peripheral #(
    parameter logic [7:0] BaseAddr   = 8'hE0,
    parameter int         ClksPerBit = 868,
    parameter int         FifoDepth  = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
    output logic       TXD
);
    localparam int PtrW   = $clog2(FifoDepth);
    localparam int CountW = PtrW + 1;
    localparam int CntW   = 12;
    localparam logic [CntW-1:0]   BitLast   = CntW'(ClksPerBit - 1);
    localparam logic [CountW-1:0] CountFull = CountW'(FifoDepth);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // Bus decode
    logic hit_data, hit_ctrl, hit_irq;
    logic wr_data, wr_ctrl, wr_irq;

    assign hit_data = (BUS_ADDR == BaseAddr);
    assign hit_ctrl = (BUS_ADDR == BaseAddr + 8'd1);
    assign hit_irq  = (BUS_ADDR == BaseAddr + 8'd2);
    assign wr_data  = BUS_WE && hit_data;
    assign wr_ctrl  = BUS_WE && hit_ctrl;
    assign wr_irq   = BUS_WE && hit_irq;

    // State
    logic [7:0]        fifo_mem_q [FifoDepth];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_pending_q, irq_pending_d;
    tx_state_t         state_q, state_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              bus_oe_q, bus_oe_d;
    logic [7:0]        bus_rdata_q, bus_rdata_d;

    logic fifo_empty, fifo_full, fifo_push, fifo_pop, flush;
    logic overflow_set, irq_trigger, bit_end, busy;

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CountFull);
    assign flush        = wr_ctrl && BUS_DATA[1];
    // A pop on the same edge frees a slot, so a write to a full FIFO is
    // still accepted in that case.
    assign fifo_push    = wr_data && (!fifo_full || fifo_pop);
    assign overflow_set = wr_data && fifo_full && !fifo_pop;
    assign bit_end      = (bit_cnt_q == BitLast);
    assign busy         = (state_q != S_IDLE);

    // FIFO pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fifo_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (fifo_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            case ({fifo_push, fifo_pop})
                2'b10:   count_d = count_q + CountW'(1);
                2'b01:   count_d = count_q - CountW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Transmit FSM
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        fifo_pop    = 1'b0;
        irq_trigger = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit, no idle gap.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_mem_q[rd_ptr_q];
                        state_d  = S_START;
                    end else begin
                        irq_trigger = irq_en_q;
                        state_d     = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CntW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control/status registers and bus read data
    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl || wr_irq) irq_en_d = BUS_DATA[0];

        overflow_d = overflow_q;
        if (overflow_set)                  overflow_d = 1'b1;
        else if (wr_ctrl && BUS_DATA[2])   overflow_d = 1'b0;

        // A new trigger beats a simultaneous acknowledge.
        irq_pending_d = irq_pending_q;
        if (irq_trigger)             irq_pending_d = 1'b1;
        else if (BUS_INTERRUPT_ACK)  irq_pending_d = 1'b0;

        bus_oe_d    = !BUS_WE && (hit_data || hit_ctrl || hit_irq);
        bus_rdata_d = 8'h00;
        if (hit_data)
            bus_rdata_d = 8'(count_q);
        else if (hit_ctrl)
            bus_rdata_d = {3'b000, overflow_q, irq_pending_q, busy, fifo_full, fifo_empty};
        else if (hit_irq)
            bus_rdata_d = {7'b0, irq_en_q};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            irq_en_q      <= 1'b0;
            irq_pending_q <= 1'b0;
            state_q       <= S_IDLE;
            bit_cnt_q     <= '0;
            bit_idx_q     <= '0;
            shift_q       <= 8'h00;
            bus_oe_q      <= 1'b0;
            bus_rdata_q   <= 8'h00;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            irq_en_q      <= irq_en_d;
            irq_pending_q <= irq_pending_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            bus_oe_q      <= bus_oe_d;
            bus_rdata_q   <= bus_rdata_d;
        end
    end

    // FIFO storage has no reset; occupancy is tracked by count_q.
    always_ff @(posedge CLK) begin
        if (fifo_push) fifo_mem_q[wr_ptr_q] <= BUS_DATA;
    end

    // TXD is decoded from state registers so reset forces it high at once.
    always_comb begin
        case (state_q)
            S_START: TXD = 1'b0;
            S_DATA:  TXD = shift_q[0];
            default: TXD = 1'b1;
        endcase
    end

    assign BUS_INTERRUPT_RAISE = irq_pending_q;
    assign BUS_DATA = bus_oe_q ? bus_rdata_q : 8'hzz;

endmodule

// File: tb/tb_uart_tx_bus_peripheral.sv
`timescale 1ns/1ps
module tb_uart_tx_bus_peripheral;
    localparam int N = 4;
    localparam logic [7:0] A_DATA = 8'hE0;
    localparam logic [7:0] A_CTRL = 8'hE1;
    localparam logic [7:0] A_IRQ  = 8'hE2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    tri1  [7:0] bus_data;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_we = 1'b0;
    logic       bus_ack = 1'b0;
    logic       drv_en = 1'b0;
    logic [7:0] drv_val = 8'h00;
    logic       raise;
    logic       txd;

    assign bus_data = drv_en ? drv_val : 8'hzz;

    uart_tx_bus_peripheral #(
        .BaseAddr  (8'hE0),
        .ClksPerBit(N),
        .FifoDepth (4)
    ) dut (
        .CLK                (clk),
        .RESET              (rst_n),
        .BUS_DATA           (bus_data),
        .BUS_ADDR           (bus_addr),
        .BUS_WE             (bus_we),
        .BUS_INTERRUPT_RAISE(raise),
        .BUS_INTERRUPT_ACK  (bus_ack),
        .TXD                (txd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_total = 0;
    int n_bad = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard: expected bytes queued at write time, popped per frame.
    logic [7:0] exp_q[$];
    int         start_q[$];
    bit         mon_en = 1'b1;
    bit         mon_busy = 1'b0;

    initial begin
        logic [7:0] mon_data;
        bit         mon_bad;
        bit         mon_have;
        int         mon_start;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && txd === 1'b0) begin
                mon_busy  = 1'b1;
                mon_start = cyc;
                start_q.push_back(cyc);
                mon_bad   = 1'b0;
                mon_data  = 8'h00;
                for (int c = 1; c < N; c++) begin
                    @(negedge clk);
                    if (txd !== 1'b0) mon_bad = 1'b1;
                end
                for (int b = 0; b < 8; b++) begin
                    for (int c = 0; c < N; c++) begin
                        @(negedge clk);
                        if (c == 0) mon_data[b] = txd;
                        else if (txd !== mon_data[b]) mon_bad = 1'b1;
                    end
                end
                for (int c = 0; c < N; c++) begin
                    @(negedge clk);
                    if (txd !== 1'b1) mon_bad = 1'b1;
                end
                $display("frame %02h started cyc %0d", mon_data, mon_start);
                check_value("frame_shape", mon_bad, 1'b0);
                mon_have = (exp_q.size() > 0);
                check_value("frame_expected", mon_have, 1'b1);
                if (mon_have) check_value("frame_data", mon_data, exp_q.pop_front());
                mon_busy = 1'b0;
            end
        end
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_addr = a;
        bus_we   = 1'b1;
        drv_val  = d;
        drv_en   = 1'b1;
        @(posedge clk);
        #1;
        bus_we   = 1'b0;
        bus_addr = 8'h00;
        drv_en   = 1'b0;
        $display("wr [%02h] <= %02h at cyc %0d", a, d, cyc);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        bus_addr = a;
        bus_we   = 1'b0;
        @(posedge clk);
        #1;
        bus_addr = 8'h00;
        @(negedge clk);
        d = bus_data;
        @(posedge clk);
        #1;
        $display("rd [%02h] => %02h at cyc %0d", a, d, cyc);
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_read(a, d);
        check_value(tag, d, exp);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check_value("drain_in_time", (n < budget), 1'b1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int s0;
        int s1;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_value("reset_txd", txd, 1'b1);
        check_value("reset_raise", raise, 1'b0);
        read_check("reset_status", A_CTRL, 8'h01);
        read_check("reset_count", A_DATA, 8'h00);
        read_check("reset_irq_en", A_IRQ, 8'h00);

        // Tristate behaviour
        bus_read(A_CTRL, rd);
        check_value("tri_read_window", rd, 8'h01);
        @(negedge clk);
        check_value("tri_released_after", bus_data, 8'hFF);
        @(posedge clk);
        #1;
        read_check("tri_unowned", 8'h10, 8'hFF);
        bus_write(A_CTRL, 8'h00);
        @(negedge clk);
        check_value("tri_after_write", bus_data, 8'hFF);
        @(posedge clk);
        #1;

        // Single byte
        start_q.delete();
        exp_q.push_back(8'hA5);
        bus_write(A_DATA, 8'hA5);
        s0 = cyc;
        read_check("single_status_queued", A_CTRL, 8'h00);
        read_check("single_status_busy", A_CTRL, 8'h05);
        wait_drain(200);
        check_value("single_frames", start_q.size(), 1);
        check_value("single_latency", (start_q.size() > 0) ? start_q[0] : -1, s0 + 1);
        check_value("single_txd_idle", txd, 1'b1);
        read_check("single_status_done", A_CTRL, 8'h01);

        // Back-to-back
        start_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        bus_write(A_DATA, 8'h00);
        s0 = cyc;
        bus_write(A_DATA, 8'hFF);
        read_check("b2b_count", A_DATA, 8'h01);
        wait_drain(300);
        check_value("b2b_frames", start_q.size(), 2);
        if (start_q.size() >= 2) begin
            check_value("b2b_first_start", start_q[0], s0 + 1);
            check_value("b2b_no_gap", start_q[1] - start_q[0], 10 * N);
        end

        // Overflow
        for (int i = 0; i < 6; i++) begin
            if (i < 5) exp_q.push_back(8'(8'h11 + i));
            bus_write(A_DATA, 8'(8'h11 + i));
        end
        read_check("ovf_status", A_CTRL, 8'h16);
        read_check("ovf_count", A_DATA, 8'h04);
        bus_write(A_CTRL, 8'h04);
        read_check("ovf_cleared", A_CTRL, 8'h06);
        wait_drain(600);
        read_check("ovf_done", A_CTRL, 8'h01);

        // Flush: in-flight frame completes, queued bytes discarded
        exp_q.push_back(8'h21);
        bus_write(A_DATA, 8'h21);
        bus_write(A_DATA, 8'h22);
        bus_write(A_DATA, 8'h23);
        bus_write(A_CTRL, 8'h02);
        read_check("flush_count", A_DATA, 8'h00);
        wait_drain(300);
        read_check("flush_done", A_CTRL, 8'h01);

        // Interrupt
        bus_write(A_CTRL, 8'h01);
        exp_q.push_back(8'h3C);
        bus_write(A_DATA, 8'h3C);
        check_value("irq_not_yet", raise, 1'b0);
        wait_drain(200);
        check_value("irq_raised", raise, 1'b1);
        read_check("irq_en_readback", A_IRQ, 8'h01);
        read_check("irq_status", A_CTRL, 8'h09);
        repeat (5) @(posedge clk);
        #1;
        check_value("irq_held", raise, 1'b1);

        // ACK on the same edge as a new trigger: set wins
        start_q.delete();
        exp_q.push_back(8'hC3);
        bus_write(A_DATA, 8'hC3);
        n = 0;
        while (start_q.size() == 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value("irq2_started", start_q.size(), 1);
        s1 = (start_q.size() > 0) ? start_q[0] : cyc;
        while (cyc < s1 + 10 * N - 1) begin
            @(posedge clk);
            #1;
        end
        bus_ack = 1'b1;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        @(negedge clk);
        check_value("irq_set_beats_ack", raise, 1'b1);
        wait_drain(100);

        // Masking does not clear a pending request
        bus_write(A_IRQ, 8'h00);
        check_value("mask_keeps_pending", raise, 1'b1);
        read_check("mask_irq_en", A_IRQ, 8'h00);
        bus_ack = 1'b1;
        @(posedge clk);
        #1;
        bus_ack = 1'b0;
        check_value("irq_acked", raise, 1'b0);
        exp_q.push_back(8'h96);
        bus_write(A_DATA, 8'h96);
        wait_drain(200);
        check_value("masked_no_trigger", raise, 1'b0);

        // Leave a pending request so reset has something to clear
        bus_write(A_CTRL, 8'h01);
        exp_q.push_back(8'h69);
        bus_write(A_DATA, 8'h69);
        wait_drain(200);
        check_value("irq_before_reset", raise, 1'b1);

        // Reset mid-frame
        mon_en = 1'b0;
        for (int i = 0; i < 6; i++) bus_write(A_DATA, 8'(8'h40 + i));
        read_check("pre_reset_status", A_CTRL, 8'h1E);
        repeat (6) @(posedge clk);
        #1;
        check_value("pre_reset_txd", txd, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_value("async_reset_txd", txd, 1'b1);
        check_value("async_reset_raise", raise, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        read_check("post_reset_status", A_CTRL, 8'h01);
        read_check("post_reset_count", A_DATA, 8'h00);
        read_check("post_reset_irq_en", A_IRQ, 8'h00);
        repeat (4) @(posedge clk);
        #1;
        check_value("post_reset_txd", txd, 1'b1);
        mon_en = 1'b1;
        exp_q.push_back(8'h81);
        bus_write(A_DATA, 8'h81);
        wait_drain(200);
        read_check("final_status", A_CTRL, 8'h01);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_bus_peripheral.md
Name: uart_tx_bus_peripheral

Overview:
- Memory-mapped UART transmitter on the shared 8-bit processor bus, alongside the data RAM; uses the same bus timing (BUS_DATA, BUS_ADDR, BUS_WE).
- The processor writes bytes into a 4-deep TX FIFO. The block serialises them as 8N1 frames on TXD.
- Raises a bus interrupt when the transmitter drains.

Parameters:
- BaseAddr, 8'hE0, first of 3 bus addresses owned by the block (BaseAddr..BaseAddr+2).
- ClksPerBit, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..4095.
- FifoDepth, 4, TX FIFO entries; fixed power of two.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  asynchronous, active-low reset.
- BUS_DATA  inout  8  shared data bus; driven only as defined below, else 8'hZZ.
- BUS_ADDR  input  8  bus address.
- BUS_WE  input  1  1 = processor write, 0 = read.
- BUS_INTERRUPT_RAISE  output  1  TX-drained interrupt request.
- BUS_INTERRUPT_ACK  input  1  interrupt acknowledge from processor.
- TXD  output  1  serial output; idle high.

Behaviour:
- Register map:
  - BaseAddr+0, write: push byte into FIFO. Read: returns {5'b0, count[2:0]}.
  - BaseAddr+1, read: STATUS = {3'b0, overflow, irq_pending, busy, full, empty}.
  - BaseAddr+1, write: CTRL. bit0 = irq_enable (stored). bit1 = flush FIFO (self-clearing). bit2 = clear overflow (self-clearing).
  - BaseAddr+2, read/write: irq_enable readback/write as bit0; other bits read 0.
- Bus timing matches the RAM:
  - Address and WE are sampled on posedge k.
  - A read at an owned address registers read data at k. BUS_DATA is driven for exactly the cycle k..k+1, then released.
  - Non-owned address or BUS_WE=1: BUS_DATA = Z.
- Reset (async, RESET=0): FIFO empty, count=0, FSM IDLE, TXD=1, BUS_INTERRUPT_RAISE=0, irq_enable=0, overflow=0, BUS_DATA released.
  - Reset asserted mid-frame forces TXD=1 immediately; the frame is abandoned.
- FIFO push/pop:
  - Push on write to BaseAddr+0 when not full.
  - Write while full: data dropped, overflow set (sticky until CTRL bit2).
  - Push and pop on the same edge while full: push accepted, count unchanged.
  - Push and pop on the same edge while count=1: both occur, count stays 1.
  - Pointers wrap modulo FifoDepth.
  - Flush empties the FIFO. A frame in progress completes normally.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter (0..ClksPerBit-1) and a bit index (0..7).
  - IDLE: TXD=1, busy=0. If FIFO non-empty, pop the head into the shift register and go to START.
  - Latency: a write to an empty FIFO at edge k gives TXD=0 from edge k+1.
  - START: TXD=0 for ClksPerBit cycles, then go to DATA.
  - DATA: TXD = shift[0], LSB first, ClksPerBit cycles per bit, 8 bits, then go to STOP.
  - STOP: TXD=1 for ClksPerBit cycles.
    - At the end of STOP, if FIFO non-empty: pop and go to START with no idle gap.
    - Otherwise go to IDLE.
  - busy=1 in START/DATA/STOP.
  - One frame = exactly 10*ClksPerBit cycles.
- Interrupt:
  - Trigger: at the STOP→IDLE transition (FIFO empty), if irq_enable=1, set irq_pending; BUS_INTERRUPT_RAISE = irq_pending.
  - irq_pending holds until BUS_INTERRUPT_ACK=1 is sampled.
  - ACK and a new trigger on the same edge: set wins.
  - irq_enable=0 masks new triggers only; it does not clear a pending request.

Test Plan:
- Reset: drive RESET=0 mid-frame (ClksPerBit=4) → TXD=1 at once, RAISE=0, STATUS read = 8'h01 after release.
- Single byte: write 8'hA5 to 0xE0 at edge k → TXD=0 from k+1 for 4 cycles, then bits 1,0,1,0,0,1,0,1 (4 cycles each), stop=1; total 40 cycles; busy clear after.
- Back-to-back: write 8'h00, 8'hFF on consecutive cycles → two frames, 80 cycles total, no idle cycle between stop and second start; count reads 1 during frame 1.
- Overflow: 6 writes (0x11..0x16) at one per cycle with TX active → first popped immediately, 4 queued, last dropped; STATUS bit4=1, full=1; CTRL write 8'h04 clears overflow.
- Interrupt: CTRL=8'h01, send 8'h3C → RAISE=1 at frame end, held until ACK; ACK on the same edge as a new trigger → RAISE stays 1.
- Bus tristate: read 0xE1 at edge k → BUS_DATA driven only during k..k+1; read 0x10 or write 0xE1 → BUS_DATA stays Z.
